stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stopwatch_ctrl: stopwatch/countdown control FSM, ms tick and preset; rev 1.0|
// +---------------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int MAX_MS   = 5999999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startstop,
  input  logic        prog,
  input  logic        up,
  input  logic        inc,
  input  logic        min,
  input  logic        clear,
  input  logic [22:0] t_ms,
  output logic        tick_ms,
  output logic        count_en,
  output logic        count_up,
  output logic        load,
  output logic [22:0] load_val,
  output logic [2:0]  state,
  output logic        zero
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_PROG  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [22:0]    MAX_V     = 23'(MAX_MS);
  localparam logic [23:0]    STEP_MIN  = 24'd60000;
  localparam logic [23:0]    STEP_SEC  = 24'd1000;

  state_t          state_q, state_d;
  logic            count_up_q, count_up_d;
  logic            load_q, load_d;
  logic [22:0]     load_val_q, load_val_d;
  logic [22:0]     preset_q, preset_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            ss_prev_q, inc_prev_q, min_prev_q, clr_prev_q;

  logic            ss_rise, inc_rise, min_rise, clr_rise;
  logic [23:0]     preset_sum;
  logic [22:0]     clr_val;
  logic            at_limit;

  assign ss_rise  = startstop & ~ss_prev_q;
  assign inc_rise = inc       & ~inc_prev_q;
  assign min_rise = min       & ~min_prev_q;
  assign clr_rise = clear     & ~clr_prev_q;

  assign clr_val  = count_up_q ? 23'd0 : preset_q;
  assign at_limit = count_up_q ? (t_ms >= MAX_V) : (t_ms == 23'd0);

  assign tick_ms  = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);
  assign count_en = tick_ms & ~load_q & ~at_limit;
  assign count_up = count_up_q;
  assign load     = load_q;
  assign load_val = load_val_q;
  assign state    = state_q;
  assign zero     = (state_q == S_DONE);

  always_comb begin
    state_d    = state_q;
    count_up_d = count_up_q;
    load_d     = 1'b0;
    load_val_d = load_val_q;
    preset_d   = preset_q;
    preset_sum = {1'b0, preset_q} + (min_rise ? STEP_MIN : STEP_SEC);

    unique case (state_q)
      S_IDLE: begin
        if (clr_rise) begin
          load_d     = 1'b1;
          load_val_d = clr_val;
        end else if (ss_rise) begin
          state_d    = S_RUN;
          count_up_d = up;
        end else if (prog) begin
          state_d = S_PROG;
        end
      end
      S_RUN: begin
        if (clr_rise) begin
          load_d     = 1'b1;
          load_val_d = clr_val;
        end else if (ss_rise) begin
          state_d = S_PAUSE;
        end else if (!count_up_q && (t_ms == 23'd0)) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (clr_rise) begin
          state_d    = S_IDLE;
          load_d     = 1'b1;
          load_val_d = clr_val;
        end else if (ss_rise) begin
          state_d = S_RUN;
        end else if (prog) begin
          state_d = S_PROG;
        end
      end
      S_PROG: begin
        // min wins over inc; overshooting the limit wraps the preset to zero
        if (min_rise || inc_rise) begin
          preset_d = (preset_sum > {1'b0, MAX_V}) ? 23'd0 : preset_sum[22:0];
        end
        if (!prog) begin
          state_d    = S_IDLE;
          load_d     = 1'b1;
          load_val_d = up ? 23'd0 : preset_q;
        end
      end
      S_DONE: begin
        if (ss_rise || clr_rise) begin
          state_d    = S_IDLE;
          load_d     = 1'b1;
          load_val_d = preset_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_d) begin
      tick_cnt_d = '0;
    end else if (state_q == S_RUN) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_up_q <= 1'b1;
      load_q     <= 1'b0;
      load_val_q <= 23'd0;
      preset_q   <= 23'd0;
      tick_cnt_q <= '0;
      ss_prev_q  <= 1'b0;
      inc_prev_q <= 1'b0;
      min_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_up_q <= count_up_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      preset_q   <= preset_d;
      tick_cnt_q <= tick_cnt_d;
      ss_prev_q  <= startstop;
      inc_prev_q <= inc;
      min_prev_q <= min;
      clr_prev_q <= clear;
    end
  end

endmodule
`default_nettype wire
